// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO behind the UART receiver.
// First-word-fall-through read port with a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DataLength = 8,
  parameter int Depth = 16,
  localparam int AW = $clog2(Depth)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DataLength-1:0] i_wr_data,
  input  logic                  i_parity_error,
  input  logic                  i_stop_bit_error,
  output logic [DataLength-1:0] o_rd_data,
  output logic                  o_rd_parity_error,
  output logic                  o_rd_stop_bit_error,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [AW:0]           o_count,
  output logic                  o_overflow,
  input  logic                  i_clr_overflow
);

  localparam int EW = DataLength + 2;

  logic [EW-1:0] mem [Depth];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [EW-1:0] head;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          overflow;

  // Occupancy and handshake decode; a pop frees a slot for a same-cycle write.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
            (wr_ptr[AW] != rd_ptr[AW]);
    pop   = !empty && i_rd_ready;
    push  = i_wr_en && (!full || pop);
    drop  = i_wr_en && full && !pop;
  end

  // Pointer registers; the extra MSB distinguishes full from empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {i_stop_bit_error, i_parity_error, i_wr_data};
    end
  end

  // Sticky overflow: a dropped write outranks a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Head entry presented combinationally, zeroed while empty.
  always_comb begin
    head                = mem[rd_ptr[AW-1:0]];
    o_rd_data           = '0;
    o_rd_parity_error   = 1'b0;
    o_rd_stop_bit_error = 1'b0;
    if (!empty) begin
      o_rd_data           = head[DataLength-1:0];
      o_rd_parity_error   = head[DataLength];
      o_rd_stop_bit_error = head[DataLength+1];
    end
  end

  assign o_rd_valid = !empty;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = wr_ptr - rd_ptr;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Reference model is a plain queue with a size limit.
module tb_uart_rx_fifo;

  localparam int DL = 8;
  localparam int DEPTH = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_wr_en;
  logic [DL-1:0] i_wr_data;
  logic          i_parity_error;
  logic          i_stop_bit_error;
  logic [DL-1:0] o_rd_data;
  logic          o_rd_parity_error;
  logic          o_rd_stop_bit_error;
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic          o_empty;
  logic          o_full;
  logic [4:0]    o_count;
  logic          o_overflow;
  logic          i_clr_overflow;

  int errors = 0;
  int checks = 0;

  logic [DL+1:0] exp_q [$];
  logic          m_ovf = 1'b0;

  uart_rx_fifo #(.DataLength(DL), .Depth(DEPTH)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_wr_en            (i_wr_en),
    .i_wr_data          (i_wr_data),
    .i_parity_error     (i_parity_error),
    .i_stop_bit_error   (i_stop_bit_error),
    .o_rd_data          (o_rd_data),
    .o_rd_parity_error  (o_rd_parity_error),
    .o_rd_stop_bit_error(o_rd_stop_bit_error),
    .o_rd_valid         (o_rd_valid),
    .i_rd_ready         (i_rd_ready),
    .o_empty            (o_empty),
    .o_full             (o_full),
    .o_count            (o_count),
    .o_overflow         (o_overflow),
    .i_clr_overflow     (i_clr_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; compare against the
  // model, then advance the model by the inputs about to be clocked in.
  always @(negedge i_clk) begin
    logic [DL+1:0] e;
    logic          pop;
    logic          push;
    logic          drop;
    if (i_rst) begin
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_valid", 32'(o_rd_valid), 32'd0);
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_full", 32'(o_full), 32'd0);
      chk("rst_ovf", 32'(o_overflow), 32'd0);
      chk("rst_data", 32'(o_rd_data), 32'd0);
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      chk("count", 32'(o_count), 32'(exp_q.size()));
      chk("valid", 32'(o_rd_valid), 32'(exp_q.size() > 0));
      chk("empty", 32'(o_empty), 32'(exp_q.size() == 0));
      chk("full", 32'(o_full), 32'(exp_q.size() == DEPTH));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      if (exp_q.size() == 0) begin
        chk("empty_out",
            32'({o_rd_stop_bit_error, o_rd_parity_error, o_rd_data}),
            32'd0);
      end
      pop = (exp_q.size() > 0) && i_rd_ready;
      if (pop) begin
        e = exp_q.pop_front();
        chk("pop_entry",
            32'({o_rd_stop_bit_error, o_rd_parity_error, o_rd_data}),
            32'(e));
      end
      push = i_wr_en && (exp_q.size() < DEPTH);
      drop = i_wr_en && !push;
      if (push) begin
        exp_q.push_back({i_stop_bit_error, i_parity_error, i_wr_data});
      end
      if (drop) m_ovf = 1'b1;
      else if (i_clr_overflow) m_ovf = 1'b0;
    end
  end

  task automatic drive(input logic wr, input logic [DL-1:0] d,
                       input logic pe, input logic se,
                       input logic rdy, input logic clr);
    @(posedge i_clk);
    #1;
    i_wr_en          = wr;
    i_wr_data        = d;
    i_parity_error   = pe;
    i_stop_bit_error = se;
    i_rd_ready       = rdy;
    i_clr_overflow   = clr;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [DL-1:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DL'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) rd();
  endtask

  initial begin
    i_rst = 1'b1;
    i_wr_en = 1'b0;
    i_wr_data = '0;
    i_parity_error = 1'b0;
    i_stop_bit_error = 1'b0;
    i_rd_ready = 1'b0;
    i_clr_overflow = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge i_clk);
    chk("a5_valid", 32'(o_rd_valid), 32'd1);
    chk("a5_data", 32'(o_rd_data), 32'hA5);
    chk("a5_parity", 32'(o_rd_parity_error), 32'd1);
    chk("a5_count", 32'(o_count), 32'd1);
    rd();
    idle();
    @(negedge i_clk);
    chk("a5_popped_empty", 32'(o_empty), 32'd1);
    chk("a5_popped_data", 32'(o_rd_data), 32'd0);

    for (int i = 0; i < DEPTH; i++) wr(DL'(i));
    wr(8'hFF);
    idle();
    @(negedge i_clk);
    chk("fill_full", 32'(o_full), 32'd1);
    chk("fill_count", 32'(o_count), 32'd16);
    chk("drop_ovf", 32'(o_overflow), 32'd1);
    chk("drop_head", 32'(o_rd_data), 32'h00);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    fill_random();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge i_clk);
    chk("fullpop_count", 32'(o_count), 32'd16);
    chk("fullpop_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) rd();
    idle();
    @(negedge i_clk);
    chk("last_is_55", 32'(o_rd_data), 32'h55);
    drain();

    for (int i = 0; i < 5; i++) wr(DL'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, DL'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    idle();
    @(negedge i_clk);
    chk("stream_count", 32'(o_count), 32'd5);
    chk("stream_ovf", 32'(o_overflow), 32'd0);
    drain();

    fill_random();
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge i_clk);
    chk("race_ovf_set", 32'(o_overflow), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge i_clk);
    chk("clr_ovf", 32'(o_overflow), 32'd0);

    wr(8'hEE);
    for (int i = 0; i < DEPTH - 5; i++) rd();
    idle();
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    chk("arst_count", 32'(o_count), 32'd0);
    chk("arst_valid", 32'(o_rd_valid), 32'd0);
    chk("arst_ovf", 32'(o_overflow), 32'd0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    wr(8'h3C);
    idle();
    @(negedge i_clk);
    chk("post_rst_head", 32'(o_rd_data), 32'h3C);
    drain();

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), DL'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0));
    end
    drain();
    idle();
    @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
